// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter for a shared bus with NUM_MASTERS
// requesters. A grant is issued one edge after a request is seen in IDLE and
// held until the owner drops its request, the slave signals done, or the hold
// timer expires. Every release is followed by a single idle turnaround cycle.
// All outputs come straight from flops.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int MSEL_W        = $clog2(NUM_MASTERS),
    localparam int HOLD_W        = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] breq,
    input  logic                   done,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [MSEL_W-1:0]      msel,
    output logic                   bus_busy,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    // Master NUM_MASTERS-1 is the notional previous owner out of reset, so
    // the upward scan starts at master 0.
    localparam logic [MSEL_W-1:0] LAST_RST = MSEL_W'(NUM_MASTERS - 1);
    // Hold count at which the owner is forcibly released.
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(TIMEOUT_CYCLES - 1);

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] bgrant_q;
    logic [MSEL_W-1:0]      msel_q;
    logic [MSEL_W-1:0]      last_owner_q;
    logic                   bus_busy_q;
    logic                   timeout_err_q;
    logic [HOLD_W-1:0]      hold_q;

    logic [MSEL_W-1:0]      winner_s;
    logic [MSEL_W-1:0]      cand_s;
    logic                   found_s;
    logic                   owner_req_s;
    logic                   hold_max_s;

    // One-hot decode of a master index.
    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MSEL_W-1:0] idx);
        logic [NUM_MASTERS-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Round-robin pick: first requester scanning upward from last_owner+1,
    // wrapping, with last_owner itself considered last.
    always_comb begin
        winner_s = last_owner_q;
        found_s  = 1'b0;
        cand_s   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand_s = MSEL_W'((int'(last_owner_q) + k) % NUM_MASTERS);
            if (!found_s && breq[cand_s]) begin
                winner_s = cand_s;
                found_s  = 1'b1;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Release conditions seen by the current owner.
    always_comb begin
        owner_req_s = breq[msel_q];
        hold_max_s  = (hold_q == HOLD_MAX);
    end

    // Arbitration FSM with registered grant, select, busy and timeout outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            bgrant_q      <= '0;
            msel_q        <= '0;
            last_owner_q  <= LAST_RST;
            bus_busy_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            hold_q        <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|breq) begin
                        state_q      <= ST_OWNED;
                        bgrant_q     <= onehot(winner_s);
                        msel_q       <= winner_s;
                        last_owner_q <= winner_s;
                        bus_busy_q   <= 1'b1;
                        hold_q       <= '0;
                    end else begin
                        state_q      <= ST_IDLE;
                    end
                end
                ST_OWNED: begin
                    // done and a dropped request on the same edge are one release.
                    if (done || !owner_req_s) begin
                        state_q       <= ST_TURN;
                        bgrant_q      <= '0;
                        bus_busy_q    <= 1'b0;
                        hold_q        <= '0;
                    end else if (hold_max_s) begin
                        state_q       <= ST_TURN;
                        bgrant_q      <= '0;
                        bus_busy_q    <= 1'b0;
                        hold_q        <= '0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        hold_q        <= hold_q + HOLD_W'(1);
                    end
                end
                ST_TURN: begin
                    // Turnaround: bus stays idle; done here is ignored.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    bgrant_q   <= '0;
                    bus_busy_q <= 1'b0;
                    hold_q     <= '0;
                end
            endcase
        end
    end

    assign bgrant      = bgrant_q;
    assign msel        = msel_q;
    assign bus_busy    = bus_busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Testbench for bus_arbiter_rr with four masters and an 8-cycle hold limit:
// a directed vector table, hand-written timeout and async-reset sequences,
// and randomized traffic checked against a behavioural reference model.
module tb_bus_arbiter_rr;

    localparam int N = 4;
    localparam int T = 8;

    logic         clk;
    logic         rstn;
    logic [N-1:0] breq;
    logic         done;
    logic [N-1:0] bgrant;
    logic [1:0]   msel;
    logic         bus_busy;
    logic         timeout_err;

    int checks;
    int errors;

    // Reference model state: owner index (-1 when nobody owns the bus),
    // whether a turnaround cycle is pending, previous owner, current select,
    // number of cycles the owner has held the grant, and timeout pulse.
    int m_owner;
    int m_last;
    int m_msel;
    int m_owned;
    bit m_turn;
    bit m_to;

    typedef struct {
        logic [N-1:0] req;
        logic         dn;
        logic [N-1:0] gnt;
        logic [1:0]   sel;
    } vec_t;

    vec_t tbl [18];

    logic [N-1:0] rq;
    logic [N-1:0] flip;
    logic         dn;

    bus_arbiter_rr #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .breq        (breq),
        .done        (done),
        .bgrant      (bgrant),
        .msel        (msel),
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] eg, input logic [1:0] em,
                         input logic eb, input logic et);
        checks++;
        if (bgrant !== eg || msel !== em || bus_busy !== eb || timeout_err !== et) begin
            errors++;
            $display("FAIL %s @%0t: got bgrant=%b msel=%0d busy=%b to=%b, want bgrant=%b msel=%0d busy=%b to=%b",
                     name, $time, bgrant, msel, bus_busy, timeout_err, eg, em, eb, et);
        end
    endtask

    // Drive inputs at a falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic [N-1:0] r, input logic d);
        breq = r;
        done = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_msel  = 0;
        m_owned = 0;
        m_turn  = 1'b0;
        m_to    = 1'b0;
    endtask

    // Advance the model by one rising edge with the given inputs.
    task automatic model_step(input logic [N-1:0] r, input logic d);
        int c;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (d || !r[m_owner]) begin
                m_owner = -1;
                m_turn  = 1'b1;
            end else if (m_owned == T) begin
                m_owner = -1;
                m_turn  = 1'b1;
                m_to    = 1'b1;
            end else begin
                m_owned++;
            end
        end else if (m_turn) begin
            m_turn = 1'b0;
        end else if (r != '0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (r[c] && m_owner < 0) m_owner = c;
            end
            m_last  = m_owner;
            m_msel  = m_owner;
            m_owned = 1;
        end
    endtask

    task automatic check_model(input string name);
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check(name, eg, 2'(m_msel), (m_owner >= 0), m_to);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        breq = '0;
        done = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        breq   = '0;
        done   = 1'b0;
        rq     = '0;
        model_reset();

        //            req      done  grant    sel
        tbl[0]  = '{4'b0011, 1'b0, 4'b0001, 2'd0};  // both request: master 0 first
        tbl[1]  = '{4'b0011, 1'b1, 4'b0000, 2'd0};  // done -> turnaround
        tbl[2]  = '{4'b0010, 1'b0, 4'b0000, 2'd0};  // idle
        tbl[3]  = '{4'b0011, 1'b0, 4'b0010, 2'd1};  // rotate to master 1
        tbl[4]  = '{4'b0011, 1'b0, 4'b0010, 2'd1};  // held
        tbl[5]  = '{4'b0001, 1'b0, 4'b0000, 2'd1};  // owner drops request
        tbl[6]  = '{4'b0001, 1'b1, 4'b0000, 2'd1};  // done outside ownership ignored
        tbl[7]  = '{4'b1001, 1'b0, 4'b1000, 2'd3};  // scan 2,3 -> master 3
        tbl[8]  = '{4'b1101, 1'b0, 4'b1000, 2'd3};  // new request does not disturb owner
        tbl[9]  = '{4'b0101, 1'b1, 4'b0000, 2'd3};  // drop + done together: one release
        tbl[10] = '{4'b0101, 1'b0, 4'b0000, 2'd3};  // idle
        tbl[11] = '{4'b0101, 1'b0, 4'b0001, 2'd0};  // wrap to master 0
        tbl[12] = '{4'b0100, 1'b0, 4'b0000, 2'd0};  // release
        tbl[13] = '{4'b0100, 1'b0, 4'b0000, 2'd0};  // idle
        tbl[14] = '{4'b0100, 1'b0, 4'b0100, 2'd2};  // master 2
        tbl[15] = '{4'b0000, 1'b0, 4'b0000, 2'd2};  // release
        tbl[16] = '{4'b0000, 1'b0, 4'b0000, 2'd2};  // idle, msel holds
        tbl[17] = '{4'b0100, 1'b0, 4'b0100, 2'd2};  // sole requester re-granted

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].req, tbl[i].dn);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, |tbl[i].gnt, 1'b0);
        end

        // Asynchronous reset while master 2 owns the bus.
        #2 rstn = 1'b0;
        #1 check("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        step(4'b0100, 1'b0);
        check("rst_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Hold timeout: master 1 never releases, master 2 waits.
        do_reset();
        for (int i = 0; i < T; i++) begin
            step(4'b0110, 1'b0);
            check("to_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step(4'b0110, 1'b0);
        check("to_release", 4'b0000, 2'd1, 1'b0, 1'b1);
        step(4'b0110, 1'b0);
        check("to_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        step(4'b0110, 1'b0);
        check("to_next", 4'b0100, 2'd2, 1'b1, 1'b0);

        // All masters requesting, done every 5 cycles: strict rotation.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            dn = (i % 5 == 4);
            step(4'b1111, dn);
            model_step(4'b1111, dn);
            check_model("rr_all");
        end

        // Randomized traffic: busy phase, then long holds that reach the timeout.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i < 1500) begin
                flip = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                dn   = ($urandom_range(0, 5) == 0);
            end else begin
                flip = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) &
                       4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                dn   = ($urandom_range(0, 19) == 0);
            end
            rq = rq ^ flip;
            step(rq, dn);
            model_step(rq, dn);
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of requesting master ports; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, maximum cycles one master may hold the bus; legal range 4..1023.
REQ-003 Derived width MSEL_W SHALL be ceil(log2(NUM_MASTERS)).
REQ-004 Port clk, input, 1, the single clock; every flop uses its rising edge.
REQ-005 Port rstn, input, 1, reset; asynchronous and active-low.
REQ-006 Port breq, input, NUM_MASTERS, bus request, one bit per master, level-held by the master port.
REQ-007 Port done, input, 1, one-cycle transaction-complete pulse from the slave side of the bus (ack path).
REQ-008 Port bgrant, output, NUM_MASTERS, registered one-hot bus grant.
REQ-009 Port msel, output, MSEL_W, registered index of the current owner, used by the bus data multiplexers.
REQ-010 Port bus_busy, output, 1, high while any grant is active.
REQ-011 Port timeout_err, output, 1, one-cycle pulse when an owner is forcibly released.

Function
REQ-012 States SHALL be IDLE, OWNED and TURN; all outputs SHALL be registered.
REQ-013 IDLE: with breq nonzero at a clock edge, the block SHALL pick the winner, enter OWNED, and assert bgrant[winner] and msel=winner after that same edge, giving 1-cycle grant latency.
REQ-014 Winner: the first set breq bit scanning upward from last_owner+1, wrapping modulo NUM_MASTERS, ending at last_owner itself.
REQ-015 last_owner SHALL update to the winner on every grant.
REQ-016 OWNED: bgrant SHALL stay constant while breq[owner]=1, done=0 and the hold counter is below TIMEOUT_CYCLES-1.
REQ-017 OWNED to TURN SHALL occur on done=1 or on breq[owner]=0, whichever comes first.
REQ-018 When done and breq[owner] deassert on the same edge, the block SHALL treat it as one release event.
REQ-019 Hold counter: cleared on grant, incremented each cycle in OWNED.
REQ-020 When the hold counter reaches TIMEOUT_CYCLES-1 without release, the block SHALL enter TURN and pulse timeout_err for one cycle.
REQ-021 TURN SHALL last exactly one cycle with bgrant=0 and bus_busy=0, acting as bus turnaround.
REQ-022 TURN SHALL then go to IDLE, and re-arbitration follows REQ-013.
REQ-023 A master that keeps breq high after release SHALL be re-granted only if no other master requests, per REQ-014.
REQ-024 Requests that arrive or drop while another master owns the bus SHALL NOT affect the current grant.
REQ-025 bgrant SHALL never have more than one bit set; msel SHALL hold its last value when bgrant=0.
REQ-026 A done pulse outside OWNED SHALL be ignored.

Reset
REQ-027 With rstn=0, the block SHALL asynchronously force state=IDLE, bgrant=0, msel=0, bus_busy=0, timeout_err=0, hold counter=0 and last_owner=NUM_MASTERS-1, so master 0 has first priority.
REQ-028 Reset asserted mid-ownership SHALL drop the grant immediately, with no TURN cycle.
REQ-029 The first grant after rstn rises SHALL use the REQ-013 latency.

Verification
REQ-030 N=2, breq=01 after reset -> bgrant=01 and msel=0 after the next edge; done pulse -> one TURN cycle with bgrant=00, then bgrant=00 if breq has dropped.
REQ-031 N=2, breq=11 on the same cycle after reset -> master 0 granted first; after its done, TURN, then bgrant=10.
REQ-032 N=3, breq=111 held continuously with a done every 5 cycles -> grant order 0,1,2,0,1,2; bgrant never multi-hot.
REQ-033 TIMEOUT_CYCLES=8, master 1 holds breq and no done -> bgrant released after 8 owned cycles, timeout_err high for 1 cycle, next requester granted.
REQ-034 rstn pulsed low while master 2 owns the bus (N=4) -> bgrant=0000 within the reset pulse without waiting for a clock; with breq=0100 after release, master 2 granted one edge later.
REQ-035 Owner drops breq and done=1 on the same edge -> a single TURN cycle, no double release, last_owner unchanged.
